// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU.
// Holds the opcode constants, the canonical NOP word, instruction field
// positions and the memory-mapped display address. There are no ports; every
// pipeline stage imports this package.
package cpu_isa_pkg;

  localparam int INST_BITS = 16;

  // Opcodes live in the top nibble of every instruction.
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // All-zero word decodes as NOP, so flushed slots are harmless downstream.
  localparam logic [INST_BITS-1:0] NOP_INST = 16'h0000;

  // Field positions (msb/lsb).
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 10;
  localparam int RS_MSB   = 9;
  localparam int RS_LSB   = 8;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  // Store to this address drives the display.
  localparam logic [7:0] DISPLAY_ADDR = 8'hF5;

  // Extract the opcode of a 16-bit instruction word.
  function automatic logic [3:0] opcode_of(input logic [INST_BITS-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Owns the PC, presents it combinationally on the instruction-memory address,
// and registers each fetched word into the IF/ID register. Handles decode
// stall, redirect (branch/flush), halt on HLT and a saturating retired-fetch
// counter.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   imem_addr        instruction-memory address (equals pc)
//   imem_inst        instruction-memory data, same cycle as imem_addr
//   stall            decode cannot accept; hold PC and IF/ID register
//   redirect_valid   load redirect_pc and flush IF/ID (beats stall)
//   redirect_pc      redirect target
//   if_valid         IF/ID holds a live instruction
//   if_inst, if_pc   IF/ID instruction and its PC
//   halted           fetch stopped on a HLT
//   fetch_count      instructions delivered with if_valid=1, saturating
//
// Handshake: there is no ready/valid pair on the memory side; the memory is
// combinational. Towards decode, stall acts as !ready: while stall=1 the
// IF/ID register holds and nothing is counted; a delivery happens on every
// edge where RUN, stall=0 and redirect_valid=0.
module inst_fetch
  import cpu_isa_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              halted_q, halted_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              is_hlt;

  assign is_hlt = (imem_inst[INST_W-1 -: 4] == OP_HLT);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      // Current memory word is on the wrong path: drop it, keep if_pc.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_inst_d  = NOP_W;
      state_d    = ST_RUN;
      halted_d   = 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if_inst_d  = imem_inst;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end
          if (is_hlt) begin
            // HLT is delivered once; pc parks on the HLT address.
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        ST_HALT: begin
          if_valid_d = 1'b0;
          if_inst_d  = NOP_W;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP_W;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
